// File: rtl/mealy_table_pkg.sv
// Shared types and helpers for the table-driven Mealy machine.
// Build option: MEALY_TABLE_FSM_REGOUT_EN registers the y output (see mealy_table_fsm).
package mealy_table_pkg;

    // Default geometry of the machine.
    localparam int SW_DEF          = 2;
    localparam int IW_DEF          = 2;
    localparam int OW_DEF          = 2;
    localparam int RESET_STATE_DEF = 0;

    // One transition-table entry: {next_state, out}.
    typedef struct packed {
        logic [SW_DEF-1:0] next_state;
        logic [OW_DEF-1:0] out;
    } entry_t;

    // Value every entry holds after the post-reset sweep.
    localparam entry_t CLEARED_ENTRY = '{next_state: SW_DEF'(RESET_STATE_DEF), out: '0};

    // Sweep controller phase; PH_SWEEP is what busy reports.
    typedef enum logic {
        PH_SWEEP = 1'b0,
        PH_RUN   = 1'b1
    } phase_e;

    // Number of table entries for a given state/input width.
    function automatic int table_depth(input int sw, input int iw);
        return 1 << (sw + iw);
    endfunction

endpackage

// File: rtl/mealy_table_ram.sv
// Flop-based transition table: one write port, one combinational lookup
// port for the state machine, and one registered readback port for config.
module mealy_table_ram #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] laddr_i,
    output logic [DW-1:0] ldata_o,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Table storage; contents are defined by the sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Readback register samples the entry before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign ldata_o = mem_q[laddr_i];
    assign rdata_o = rdata_q;

endmodule

// File: rtl/mealy_table_fsm.sv
// Run-time programmable Mealy machine driven by a writable transition table.
// After reset a hardware sweep clears every entry to {RESET_STATE, 0}; busy
// is high for the sweep and the machine only steps once it completes.
// Build option: define MEALY_TABLE_FSM_REGOUT_EN to register y (one cycle
// later than the combinational default); nothing else changes.
module mealy_table_fsm
    import mealy_table_pkg::*;
#(
    parameter int SW          = SW_DEF,
    parameter int IW          = IW_DEF,
    parameter int OW          = OW_DEF,
    parameter int RESET_STATE = RESET_STATE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [IW-1:0]    in_i,
    output logic [OW-1:0]    y_o,
    output logic [SW-1:0]    state_o,
    output logic             busy_o,
    input  logic             cfg_we_i,
    input  logic [SW+IW-1:0] cfg_addr_i,
    input  logic [SW+OW-1:0] cfg_wdata_i,
    output logic [SW+OW-1:0] cfg_rdata_o,
    output logic             cfg_err_o
);

    localparam int AW    = SW + IW;
    localparam int DW    = SW + OW;
    localparam int DEPTH = table_depth(SW, IW);

    localparam logic [SW-1:0] RST_ST   = SW'(RESET_STATE);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [DW-1:0] CLEARED  = {RST_ST, {OW{1'b0}}};

    phase_e        phase_q, phase_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [SW-1:0] state_q, state_d;
    logic          err_q, err_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] lookup_entry;
    logic [SW-1:0] lookup_next;
    logic [OW-1:0] lookup_out;
    logic          busy;

    assign busy        = (phase_q == PH_SWEEP);
    assign lookup_next = lookup_entry[DW-1:OW];
    assign lookup_out  = lookup_entry[OW-1:0];

    // Control registers: phase, sweep pointer, machine state, error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_SWEEP;
            clr_ptr_q <= '0;
            state_q   <= RST_ST;
            err_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            clr_ptr_q <= clr_ptr_d;
            state_q   <= state_d;
            err_q     <= err_d;
        end
    end

    // Config write contract: cfg_we_i is a single-cycle strobe sampled at the
    // edge; it is accepted only while not busy, otherwise dropped and flagged
    // by cfg_err_o on the following cycle (never flagged while rst is high).
    // Next-state logic and the shared table write port.
    always_comb begin
        phase_d   = phase_q;
        clr_ptr_d = clr_ptr_q;
        state_d   = state_q;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = cfg_addr_i;
        ram_wdata = cfg_wdata_i;
        case (phase_q)
            PH_SWEEP: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr_q;
                ram_wdata = CLEARED;
                clr_ptr_d = clr_ptr_q + 1'b1;
                err_d     = cfg_we_i;
                if (clr_ptr_q == LAST_PTR) begin
                    phase_d = PH_RUN;
                end
            end
            PH_RUN: begin
                ram_we = cfg_we_i;
                if (en_i) begin
                    state_d = lookup_next;
                end
            end
            default: phase_d = PH_SWEEP;
        endcase
        // Reset drops any pending write, including a sweep write.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    mealy_table_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .laddr_i ({state_q, in_i}),
        .ldata_o (lookup_entry),
        .raddr_i (cfg_addr_i),
        .rdata_o (cfg_rdata_o)
    );

`ifdef MEALY_TABLE_FSM_REGOUT_EN
    logic [OW-1:0] y_q;

    // Registered Mealy output, forced to zero while the sweep runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= busy ? '0 : lookup_out;
        end
    end

    assign y_o = y_q;
`else
    assign y_o = busy ? '0 : lookup_out;
`endif

    assign state_o   = state_q;
    assign busy_o    = busy;
    assign cfg_err_o = err_q;

endmodule

// File: tb/tb_mealy_table_fsm.sv
// Directed bench for mealy_table_fsm. The driver schedules expectations for
// a given cycle into exp_q; the monitor compares on the falling edge.
module tb_mealy_table_fsm;
    import mealy_table_pkg::*;

    localparam int K_Y     = 0;
    localparam int K_STATE = 1;
    localparam int K_BUSY  = 2;
    localparam int K_RDATA = 3;
    localparam int K_ERR   = 4;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] in_s;
    logic [1:0] y;
    logic [1:0] state;
    logic       busy;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_wdata;
    logic [3:0] cfg_rdata;
    logic       cfg_err;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] cleared_v;

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mealy_table_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .in_i        (in_s),
        .y_o         (y),
        .state_o     (state),
        .busy_o      (busy),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .cfg_err_o   (cfg_err)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int dly, input int kind, input logic [7:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] actual(input int kind);
        case (kind)
            K_Y:     return {6'b0, y};
            K_STATE: return {6'b0, state};
            K_BUSY:  return {7'b0, busy};
            K_RDATA: return {4'b0, cfg_rdata};
            default: return {7'b0, cfg_err};
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                checks = checks + 1;
                if (actual(exp_q[i].kind) !== exp_q[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s @cycle %0d: got %0h expected %0h",
                             exp_q[i].name, cyc, actual(exp_q[i].kind), exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d never sampled", exp_q[i].name, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cleared_v = {4'b0, CLEARED_ENTRY};
        rst = 1'b1; en = 1'b0; in_s = 2'd0;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 4'd0;
        tick(); tick();

        // Reset values.
        exp_at(0, K_STATE, 8'd0, "rst_state");
        exp_at(0, K_BUSY,  8'd1, "rst_busy");
        exp_at(0, K_Y,     8'd0, "rst_y");
        exp_at(0, K_RDATA, 8'd0, "rst_rdata");
        exp_at(0, K_ERR,   8'd0, "rst_err");
        rst = 1'b0;

        // Sweep: busy for exactly 16 observed cycles, state/y stay 0.
        for (int i = 0; i < 16; i++) begin
            exp_at(i, K_BUSY,  8'd1, "sweep_busy");
            exp_at(i, K_STATE, 8'd0, "sweep_state");
            exp_at(i, K_Y,     8'd0, "sweep_y");
        end
        exp_at(16, K_BUSY,  8'd0, "sweep_done");
        exp_at(16, K_STATE, 8'd0, "sweep_done_state");
        exp_at(16, K_Y,     8'd0, "sweep_done_y");
        tick(); tick(); tick();

        // Write while busy: dropped, cfg_err pulses once. en is ignored too.
        en = 1'b1; in_s = 2'b01;
        cfg_we = 1'b1; cfg_addr = 4'b0001; cfg_wdata = 4'b1001;
        exp_at(0, K_ERR, 8'd0, "busy_wr_err_pre");
        exp_at(1, K_ERR, 8'd1, "busy_wr_err_pulse");
        exp_at(2, K_ERR, 8'd0, "busy_wr_err_post");
        tick();
        cfg_we = 1'b0;
        repeat (12) tick();
        en = 1'b0;

        // Every entry reads back as cleared, including the dropped write.
        for (int a = 0; a < 16; a++) begin
            cfg_addr = 4'(a);
            exp_at(1, K_RDATA, cleared_v, "clear_readback");
            tick();
        end

        // Program {0,01} -> next=10, out=01 and step.
        cfg_we = 1'b1; cfg_addr = 4'b0001; cfg_wdata = 4'b1001;
        tick();
        cfg_we = 1'b0; in_s = 2'b01; en = 1'b1;
        exp_at(0, K_STATE, 8'd0, "step_pre_state");
        exp_at(1, K_RDATA, 8'h9, "wr_readback");
`ifdef MEALY_TABLE_FSM_REGOUT_EN
        exp_at(0, K_Y, 8'd0, "regout_y_lag");
        exp_at(1, K_Y, 8'd1, "regout_y");
        exp_at(2, K_Y, 8'd0, "regout_y_after");
`else
        exp_at(0, K_Y, 8'd1, "step_y");
        exp_at(1, K_Y, 8'd0, "step_y_after");
`endif
        tick();
        en = 1'b0;
        exp_at(0, K_STATE, 8'd2, "step_state");

        // Self-loop entry at {10,01}: next=10, out=11.
        cfg_we = 1'b1; cfg_addr = 4'b1001; cfg_wdata = 4'b1011;
        tick();
`ifdef MEALY_TABLE_FSM_REGOUT_EN
        exp_at(1, K_Y, 8'd3, "old_entry_y");
`else
        exp_at(0, K_Y, 8'd3, "old_entry_y");
`endif
        // Same-cycle step and overwrite with next=11, out=10.
        cfg_wdata = 4'b1110; en = 1'b1;
        tick();
        cfg_we = 1'b0; en = 1'b0;
        exp_at(0, K_STATE, 8'd2, "rbw_state");
`ifdef MEALY_TABLE_FSM_REGOUT_EN
        exp_at(1, K_Y, 8'd2, "rbw_new_y");
`else
        exp_at(0, K_Y, 8'd2, "rbw_new_y");
`endif
        exp_at(1, K_RDATA, 8'hE, "rbw_readback");
        tick();
        exp_at(0, K_STATE, 8'd2, "hold_state");
        tick();

        // Reset mid-operation with a pending write: no error pulse.
        rst = 1'b1; cfg_we = 1'b1; cfg_addr = 4'b0011; cfg_wdata = 4'hF;
        tick();
        rst = 1'b0; cfg_we = 1'b0;
        exp_at(0, K_STATE, 8'd0, "rst2_state");
        exp_at(0, K_BUSY,  8'd1, "rst2_busy");
        exp_at(0, K_ERR,   8'd0, "rst2_err");
        exp_at(0, K_Y,     8'd0, "rst2_y");
        exp_at(0, K_RDATA, 8'd0, "rst2_rdata");
        repeat (7) tick();

        // Reset at sweep cycle 7: sweep restarts for a full 16 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_at(i, K_BUSY,  8'd1, "resweep_busy");
            exp_at(i, K_STATE, 8'd0, "resweep_state");
        end
        exp_at(16, K_BUSY, 8'd0, "resweep_done");
        repeat (16) tick();
        cfg_addr = 4'b1001;
        exp_at(1, K_RDATA, cleared_v, "resweep_clr_9");
        tick();
        cfg_addr = 4'b0011;
        exp_at(1, K_RDATA, cleared_v, "resweep_clr_3");
        tick(); tick();

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 50 && exp_q.size() > 0; w++) tick();
        while (exp_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: expectation for cycle %0d left unchecked", exp_q[0].name, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
